// File: rtl/mskand_hpc3o_tof_pipe_if.sv
// Handshake bundle for the masked AND/Toffoli pipe: input sharings, randomness and output sharing.
// Share s of a sharing occupies bits [s*W +: W].
interface mskand_hpc3o_tof_pipe_if #(
    parameter int d = 2,
    parameter int W = 8
);
    localparam int RND = W * d * (d - 1);

    logic               in_valid;
    logic               in_ready;
    logic               op;
    logic [d*W-1:0]     ina;
    logic [d*W-1:0]     inb;
    logic [d*W-1:0]     inc;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [RND-1:0]     rnd;
    logic               out_valid;
    logic               out_ready;
    logic [d*W-1:0]     out;

    modport master (
        output in_valid, op, ina, inb, inc, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out
    );

    modport slave (
        input  in_valid, op, ina, inb, inc, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out
    );
endinterface

// File: rtl/mskand_hpc3o_tof_pipe.sv
// W-lane, d-share HPC3 masked gadget: out = a&b ^ (op ? c : 0), with an internal a-share register
// and optional registered output stage, all behind valid/ready handshakes.
module mskand_hpc3o_tof_pipe #(
    parameter int d      = 2,
    parameter int W      = 8,
    parameter int STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mskand_hpc3o_tof_pipe_if.slave bus
);
    localparam int RND = W * d * (d - 1);
    localparam int LR  = d * (d - 1);
    localparam int NP  = d * (d - 1) / 2;

    // k-th partner of share i, skipping i itself
    function automatic int peer(input int i, input int k);
        return (k < i) ? k : k + 1;
    endfunction

    // Pair index for the unordered pair {i, j}; randomness is symmetric in (i, j)
    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - (lo * (lo + 1)) / 2 + (hi - 1 - lo);
    endfunction

    logic [RND-1:0] rnd_w;
    logic [W-1:0]   opm;
    logic [W-1:0]   r0v [NP];
    logic [W-1:0]   r1v [NP];
    logic [W-1:0]   u_d [d][d-1];
    logic [W-1:0]   v_d [d][d-1];

    logic [W-1:0]   u_p1 [d][d-1];
    logic [W-1:0]   v_p1 [d][d-1];
    logic [W-1:0]   a_p1 [d];
    logic           vld_p1;
    logic [d*W-1:0] out_s1;

    logic in_ready_w;
    logic in_fire;
    logic s1_ready;
    logic s1_xfer;

    assign rnd_w = bus.rnd;
    assign opm   = {W{bus.op}};

    assign in_ready_w    = !vld_p1 | s1_ready;
    assign in_fire       = bus.in_valid & bus.rnd_valid & in_ready_w;
    assign s1_xfer       = vld_p1 & s1_ready;
    assign bus.in_ready  = in_ready_w;
    assign bus.rnd_ready = bus.in_valid & in_ready_w;

    // Regroup per-lane randomness into per-pair W-bit vectors
    always_comb begin
        r0v = '{default: '0};
        r1v = '{default: '0};
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < W; b++) begin
                r0v[p][b] = rnd_w[b*LR + p];
                r1v[p][b] = rnd_w[b*LR + NP + p];
            end
        end
    end

    always_comb begin
        u_d = '{default: '0};
        v_d = '{default: '0};
        for (int i = 0; i < d; i++) begin
            for (int k = 0; k < d - 1; k++) begin
                if (k == 0)
                    u_d[i][k] = (bus.ina[i*W +: W] & (r0v[pair_idx(i, peer(i, k))] ^ bus.inb[i*W +: W]))
                              ^ (opm & bus.inc[i*W +: W])
                              ^ r1v[pair_idx(i, peer(i, k))];
                else
                    u_d[i][k] = (bus.ina[i*W +: W] & r0v[pair_idx(i, peer(i, k))])
                              ^ r1v[pair_idx(i, peer(i, k))];
                v_d[i][k] = bus.inb[peer(i, k)*W +: W] ^ r0v[pair_idx(i, peer(i, k))];
            end
        end
    end

    // ---- stage 1: HPC3 share registers, loaded only on a full handshake ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            u_p1   <= '{default: '0};
            v_p1   <= '{default: '0};
            a_p1   <= '{default: '0};
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
            u_p1   <= u_d;
            v_p1   <= v_d;
            for (int i = 0; i < d; i++)
                a_p1[i] <= bus.ina[i*W +: W];
        end else if (s1_xfer) begin
            vld_p1 <= 1'b0;
        end
    end

    always_comb begin
        out_s1 = '0;
        for (int i = 0; i < d; i++) begin
            for (int k = 0; k < d - 1; k++)
                out_s1[i*W +: W] = out_s1[i*W +: W] ^ u_p1[i][k] ^ (a_p1[i] & v_p1[i][k]);
        end
    end

    generate
        if (STAGES == 1) begin : g_s1
            assign s1_ready      = bus.out_ready;
            assign bus.out_valid = vld_p1;
            assign bus.out       = out_s1;
        end else begin : g_s2
            logic           vld_p2;
            logic [d*W-1:0] out_p2;

            assign s1_ready      = !vld_p2 | bus.out_ready;
            assign bus.out_valid = vld_p2;
            assign bus.out       = out_p2;

            // ---- stage 2: registered output sharing ----
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_p2 <= 1'b0;
                    out_p2 <= '0;
                end else if (s1_xfer) begin
                    vld_p2 <= 1'b1;
                    out_p2 <= out_s1;
                end else if (bus.out_ready) begin
                    vld_p2 <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_mskand_hpc3o_tof_pipe.sv
// Bench for the masked AND/Toffoli pipe: d=2/STAGES=1 and d=3/STAGES=2 instances checked against
// a plaintext scoreboard of recombined results.
module tb_mskand_hpc3o_tof_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mskand_hpc3o_tof_pipe_if #(.d(2), .W(4)) if1 ();
    mskand_hpc3o_tof_pipe_if #(.d(3), .W(4)) if2 ();

    mskand_hpc3o_tof_pipe #(.d(2), .W(4), .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mskand_hpc3o_tof_pipe #(.d(3), .W(4), .STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int checks = 0;
    int failures = 0;
    int nf1 = 0;
    int nf2 = 0;
    logic [3:0] exp1[$];
    logic [3:0] got1[$];
    logic [3:0] exp2[$];
    logic [3:0] got2[$];
    logic [3:0] gsh1[$];

    function automatic logic [3:0] rc1(input logic [7:0] v);
        return v[3:0] ^ v[7:4];
    endfunction

    function automatic logic [3:0] rc2(input logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

    // One clock: log output transfers and input fires at the negedge, then return 1 after posedge
    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            if (if1.out_valid && if1.out_ready) begin
                got1.push_back(rc1(if1.out));
                gsh1.push_back(if1.out[3:0]);
            end
            if (if2.out_valid && if2.out_ready)
                got2.push_back(rc2(if2.out));
            if (if1.in_valid && if1.rnd_valid && if1.in_ready) begin
                exp1.push_back((rc1(if1.ina) & rc1(if1.inb)) ^ (if1.op ? rc1(if1.inc) : 4'h0));
                nf1++;
            end
            if (if2.in_valid && if2.rnd_valid && if2.in_ready) begin
                exp2.push_back((rc2(if2.ina) & rc2(if2.inb)) ^ (if2.op ? rc2(if2.inc) : 4'h0));
                nf2++;
            end
        end else begin
            exp1.delete();
            exp2.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic opv, input logic [7:0] r, input bit rs);
        logic [3:0] ma, mb, mc;
        ma = rs ? 4'($urandom) : 4'h0;
        mb = rs ? 4'($urandom) : 4'h0;
        mc = rs ? 4'($urandom) : 4'h0;
        if1.ina = {ma, a ^ ma};
        if1.inb = {mb, b ^ mb};
        if1.inc = {mc, c ^ mc};
        if1.op = opv;
        if1.rnd = r;
        if1.in_valid = 1'b1;
        if1.rnd_valid = 1'b1;
    endtask

    task automatic drive2();
        if2.ina = 12'($urandom);
        if2.inb = 12'($urandom);
        if2.inc = 12'($urandom);
        if2.op = 1'($urandom);
        if2.rnd = 24'($urandom);
        if2.in_valid = 1'b1;
        if2.rnd_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if1.in_valid = 0; if1.rnd_valid = 0; if1.op = 0; if1.ina = 0; if1.inb = 0; if1.inc = 0;
        if1.rnd = 0; if1.out_ready = 1;
        if2.in_valid = 0; if2.rnd_valid = 0; if2.op = 0; if2.ina = 0; if2.inb = 0; if2.inc = 0;
        if2.rnd = 0; if2.out_ready = 1;
        repeat (3) step();
        checks++;
        if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid1 got=%b want=0", if1.out_valid); end
        checks++;
        if (if1.out !== 8'h00) begin failures++; $display("FAIL reset_out1 got=%h want=00", if1.out); end
        checks++;
        if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid2 got=%b want=0", if2.out_valid); end
        checks++;
        if (if2.out !== 12'h000) begin failures++; $display("FAIL reset_out2 got=%h want=000", if2.out); end
        rst_n = 1'b1;
        if1.in_valid = 1; if2.in_valid = 1;
        step();
        checks++;
        if (if1.in_ready !== 1'b1 || if1.rnd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready1 in_ready=%b rnd_ready=%b want=1/1", if1.in_ready, if1.rnd_ready);
        end
        checks++;
        if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready2 got=%b want=1", if2.in_ready); end
        if1.in_valid = 0; if2.in_valid = 0;
    endtask

    task automatic test_toffoli();
        logic [3:0] g, e;
        if1.out_ready = 1;
        drive1(4'b1010, 4'b0110, 4'b0011, 1'b1, 8'h00, 1'b0);
        step();
        checks++;
        if (if1.out_valid !== 1'b1) begin failures++; $display("FAIL tof_out_valid got=%b want=1", if1.out_valid); end
        checks++;
        if (rc1(if1.out) !== 4'b0001) begin failures++; $display("FAIL tof_value got=%b want=0001", rc1(if1.out)); end
        checks++;
        if (if1.in_ready !== 1'b1) begin failures++; $display("FAIL tof_in_ready got=%b want=1", if1.in_ready); end
        drive1(4'b1010, 4'b0110, 4'b0011, 1'b0, 8'h00, 1'b0);
        step();
        checks++;
        if (rc1(if1.out) !== 4'b0010 || if1.out_valid !== 1'b1) begin
            failures++; $display("FAIL and_value got=%b vld=%b want=0010 vld=1", rc1(if1.out), if1.out_valid);
        end
        if1.in_valid = 0;
        repeat (2) step();
        checks++;
        if (got1.size() != exp1.size()) begin failures++; $display("FAIL tof_count got=%0d want=%0d", got1.size(), exp1.size()); end
        while (got1.size() > 0 && exp1.size() > 0) begin
            g = got1.pop_front(); e = exp1.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL tof_sb got=%b want=%b", g, e); end
        end
        exp1.delete(); got1.delete();
    endtask

    task automatic test_random_masks();
        logic [3:0] g, e, f;
        bit varied;
        int bad;
        gsh1.delete();
        if1.out_ready = 1; if2.out_ready = 1;
        for (int i = 0; i < 100; i++) begin
            drive1(4'b1010, 4'b0110, 4'b0011, 1'b0, 8'($urandom), 1'b1);
            drive2();
            step();
        end
        if1.in_valid = 0; if2.in_valid = 0;
        repeat (4) step();
        checks++;
        if (got1.size() != 100 || exp1.size() != 100) begin
            failures++; $display("FAIL rand1_count got=%0d exp=%0d want=100", got1.size(), exp1.size());
        end
        checks++;
        if (got2.size() != 100 || exp2.size() != 100) begin
            failures++; $display("FAIL rand2_count got=%0d exp=%0d want=100", got2.size(), exp2.size());
        end
        bad = 0;
        while (got1.size() > 0 && exp1.size() > 0) begin
            g = got1.pop_front(); e = exp1.pop_front();
            if (g !== 4'b0010) bad++;
            checks++;
            if (g !== e) begin failures++; $display("FAIL rand1_sb got=%b want=%b", g, e); end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rand1_const got=%0d wrong want=0", bad); end
        while (got2.size() > 0 && exp2.size() > 0) begin
            g = got2.pop_front(); e = exp2.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL rand2_sb got=%b want=%b", g, e); end
        end
        varied = 0;
        if (gsh1.size() > 0) begin
            f = gsh1[0];
            foreach (gsh1[k]) if (gsh1[k] !== f) varied = 1;
        end
        checks++;
        if (!varied) begin failures++; $display("FAIL rand1_share_vary got=constant want=varying"); end
        exp1.delete(); got1.delete(); exp2.delete(); got2.delete();
    endtask

    task automatic test_back_to_back();
        logic [3:0] g, e;
        logic want;
        if2.out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive2(); else if2.in_valid = 0;
            step();
            want = (i >= 1 && i <= 8);
            checks++;
            if (if2.out_valid !== want || if2.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_valid_c%0d got=%b/%b want=%b/1", i, if2.out_valid, if2.in_ready, want);
            end
        end
        checks++;
        if (got2.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", got2.size()); end
        while (got2.size() > 0 && exp2.size() > 0) begin
            g = got2.pop_front(); e = exp2.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL b2b_sb got=%b want=%b", g, e); end
        end
        exp2.delete(); got2.delete();
    endtask

    task automatic test_stall();
        logic [7:0]  hold1;
        logic [11:0] hold2;
        logic [3:0]  g, e;
        int n1, n2;
        n1 = nf1; n2 = nf2;
        hold1 = '0; hold2 = '0;
        if1.out_ready = 0; if2.out_ready = 0;
        for (int i = 0; i < 7; i++) begin
            drive1(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom), 1'b1);
            drive2();
            step();
            if (i == 0) hold1 = if1.out;
            if (i == 1) hold2 = if2.out;
            if (i >= 1) begin
                checks++;
                if (if1.out_valid !== 1'b1 || if1.out !== hold1 || if1.in_ready !== 1'b0 || if1.rnd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall1_c%0d vld=%b out=%h in_ready=%b rnd_ready=%b want=1/%h/0/0",
                             i, if1.out_valid, if1.out, if1.in_ready, if1.rnd_ready, hold1);
                end
            end
            if (i >= 2) begin
                checks++;
                if (if2.out_valid !== 1'b1 || if2.out !== hold2 || if2.in_ready !== 1'b0 || if2.rnd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall2_c%0d vld=%b out=%h in_ready=%b rnd_ready=%b want=1/%h/0/0",
                             i, if2.out_valid, if2.out, if2.in_ready, if2.rnd_ready, hold2);
                end
            end
        end
        checks++;
        if (nf1 - n1 != 1) begin failures++; $display("FAIL stall1_fires got=%0d want=1", nf1 - n1); end
        checks++;
        if (nf2 - n2 != 2) begin failures++; $display("FAIL stall2_fires got=%0d want=2", nf2 - n2); end
        if1.in_valid = 0; if2.in_valid = 0;
        if1.out_ready = 1; if2.out_ready = 1;
        repeat (4) step();
        checks++;
        if (got1.size() != 1 || got2.size() != 2) begin
            failures++; $display("FAIL stall_drain got=%0d/%0d want=1/2", got1.size(), got2.size());
        end
        while (got1.size() > 0 && exp1.size() > 0) begin
            g = got1.pop_front(); e = exp1.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL stall1_sb got=%b want=%b", g, e); end
        end
        while (got2.size() > 0 && exp2.size() > 0) begin
            g = got2.pop_front(); e = exp2.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL stall2_sb got=%b want=%b", g, e); end
        end
        exp1.delete(); got1.delete(); exp2.delete(); got2.delete();
    endtask

    task automatic test_rnd_wait();
        logic [7:0] prev;
        logic [3:0] g, e;
        int n1;
        if1.out_ready = 1;
        prev = if1.out;
        n1 = nf1;
        drive1(4'b1100, 4'b1010, 4'b0110, 1'b1, 8'($urandom), 1'b1);
        if1.rnd_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (if1.rnd_ready !== 1'b1 || if1.out_valid !== 1'b0 || if1.out !== prev) begin
                failures++;
                $display("FAIL rndwait_c%0d rnd_ready=%b vld=%b out=%h want=1/0/%h",
                         i, if1.rnd_ready, if1.out_valid, if1.out, prev);
            end
        end
        checks++;
        if (nf1 != n1) begin failures++; $display("FAIL rndwait_fires got=%0d want=0", nf1 - n1); end
        if1.rnd_valid = 1;
        step();
        checks++;
        if (if1.out_valid !== 1'b1 || rc1(if1.out) !== 4'b1110) begin
            failures++; $display("FAIL rndwait_out vld=%b val=%b want=1/1110", if1.out_valid, rc1(if1.out));
        end
        if1.in_valid = 0;
        step();
        while (got1.size() > 0 && exp1.size() > 0) begin
            g = got1.pop_front(); e = exp1.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL rndwait_sb got=%b want=%b", g, e); end
        end
        exp1.delete(); got1.delete();
    endtask

    task automatic test_reset_midflight();
        if1.out_ready = 0; if2.out_ready = 0;
        drive1(4'b1111, 4'b1111, 4'b0000, 1'b0, 8'($urandom), 1'b1);
        drive2();
        step();
        rst_n = 1'b0;
        if1.in_valid = 0; if2.in_valid = 0;
        step();
        checks++;
        if (if1.out_valid !== 1'b0 || if1.out !== 8'h00) begin
            failures++; $display("FAIL midrst1 vld=%b out=%h want=0/00", if1.out_valid, if1.out);
        end
        checks++;
        if (if2.out_valid !== 1'b0 || if2.out !== 12'h000) begin
            failures++; $display("FAIL midrst2 vld=%b out=%h want=0/000", if2.out_valid, if2.out);
        end
        rst_n = 1'b1;
        if1.out_ready = 1; if2.out_ready = 1;
        repeat (5) step();
        checks++;
        if (got1.size() != 0 || got2.size() != 0) begin
            failures++; $display("FAIL midrst_ghost got=%0d/%0d want=0/0", got1.size(), got2.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_toffoli();
        test_random_masks();
        test_back_to_back();
        test_stall();
        test_rnd_wait();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mskand_hpc3o_tof_pipe.md
Name: mskand_hpc3o_tof_pipe

Overview:
- W-lane, d-share masked Toffoli/AND gadget (HPC3 construction): out = a·b ⊕ c when op=1, out = a·b when op=0.
- The a-share delay register is internal; callers no longer supply a delayed copy of a.
- Has valid/ready handshakes on input, randomness and output, plus an optional output register stage for timing closure.
- Sits between sharing-level datapath stages, e.g. S-box nonlinear layers, that need back-pressure.

Parameters:
- d, 2, number of shares (≥2)
- W, 8, number of parallel bit lanes
- STAGES, 1, pipeline depth: 1 = HPC3 register only; 2 = adds a registered output stage
- RND, W*d*(d-1), randomness bits per input transfer (derived localparam, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input sharings present
- in_ready  out  1  block accepts input
- op  in  1  1 = AND-XOR (Toffoli), 0 = plain AND (c ignored)
- ina  in  d*W  sharing of a; bit b of share s at index s*W+b (same layout for all sharings)
- inb  in  d*W  sharing of b
- inc  in  d*W  sharing of c
- rnd_valid  in  1  fresh randomness present
- rnd_ready  out  1  randomness consumed this cycle
- rnd  in  RND  fresh randomness; lane b uses slice [b*d*(d-1) +: d*(d-1)]; lower half is r0, upper half is r1; pair (i<j) index i*d−i(i+1)/2+(j−1−i), symmetric r[i][j]=r[j][i]
- out_valid  out  1  output sharing valid
- out_ready  in  1  downstream accepts
- out  out  d*W  sharing of result

Behaviour:
- Handshakes:
  - in_fire = in_valid & rnd_valid & in_ready.
  - rnd_ready = in_valid & in_ready, so randomness is consumed only together with data.
  - No combinational path from rnd_valid to in_ready.
- Per lane, share i, j≠i, with j2 = j<i ? j : j−1:
  - u_ij = a_i·(r0_ij ⊕ b_i) ⊕ (op·c_i) ⊕ r1_ij when j2=0.
  - u_ij = a_i·r0_ij ⊕ r1_ij otherwise.
  - v_ij = b_j ⊕ r0_ij.
  - On in_fire, register u_ij, v_ij and a_i (a_reg).
  - out_i = ⊕_j u_ij ⊕ ⊕_j (a_reg_i · v_ij).
  - Recombined out equals a·b ⊕ op·c for every rnd value.
- Register enables:
  - All stage-1 registers load only on in_fire, otherwise they hold. Never load on in_valid alone: unmasked re-use of inputs is forbidden.
  - a_reg must be the same share register used in the product. No recombination across shares before a register.
- STAGES=1:
  - s1_valid is set on in_fire and cleared on out_valid & out_ready & !in_fire.
  - in_ready = !s1_valid | out_ready.
  - out is combinational from stage-1 regs; out_valid = s1_valid. Latency 1.
- STAGES=2:
  - Stage-2 register captures out on s1→s2 transfer; s1_ready = !s2_valid | out_ready.
  - in_ready = !s1_valid | s1_ready; out_valid = s2_valid. Latency 2.
  - Full throughput of 1 transfer/cycle with out_ready held high.
- Stall: out_valid & !out_ready → out and all pipeline registers hold bit-exact.
- Simultaneous accept and drain in a full pipe: both occur in the same cycle; no bubble.
- Reset (rst_n=0 at a clock edge):
  - All valid flags → 0; all share/data registers → 0; out = 0.
  - in_ready = 1 the cycle after reset if in_valid is held.
  - Mid-operation reset discards in-flight data; nothing emerges afterwards.
- out is don't-care when out_valid=0, except all-zero after reset.
- op is sampled with inputs on in_fire; a changing op does not affect in-flight data.

Test Plan:
- d=2, W=4, STAGES=1, rnd=0, a=1010 (shares 1010/0000), b=0110, c=0011, op=1, out_ready=1 → one cycle later out_valid=1; recombined out=0001; in_ready stays 1.
- Same inputs with op=0 → recombined out=0010. Repeat with 100 random rnd vectors and random re-sharings → recombined result always 0010; individual shares vary.
- STAGES=2, stream 8 transfers back-to-back with out_ready=1 → 8 consecutive out_valid cycles starting 2 cycles after the first fire, results in order.
- Fill the pipe, then hold out_ready=0 for 5 cycles → out_valid=1 and out stable; in_ready=0 (STAGES=1) or drops after 2 fires (STAGES=2); no rnd_ready pulses.
- in_valid=1 with rnd_valid=0 for 3 cycles → no fire, rnd_ready=1, registers unchanged; raising rnd_valid → fire, output next cycle.
- Reset asserted one cycle after in_fire → out_valid=0 and out=0 after the edge; the discarded word is never output.
